sr_ff_bank: RTL and testbench
=============================

Name: sr_ff_bank

Overview:
- Parametrised, clocked successor to the lab's single asynchronous RS latch: N independent set/reset storage cells sharing one clock and one clear.
- The S=R=1 condition has a defined, selectable resolution mode instead of undefined latch behaviour.
- Per-channel change pulses, sticky violation flags and a saturating violation counter.
- Used as a status/flag register bank in the lab datapath exercises.

Parameters:
- N, 4, number of channels.
- MODE, 0, S=R=1 resolution: 0 reset-dominant, 1 set-dominant, 2 toggle (JK), 3 hold-and-flag.
- INIT, {N{1'b0}}, q value loaded on reset, per channel.
- CNT_W, 8, width of the violation counter.

Ports:
- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous, active-low reset (clear).
- en  in  1  global update enable; 0 freezes q.
- s  in  N  per-channel set.
- r  in  N  per-channel reset.
- err_clr  in  1  synchronous clear of err and vcnt.
- q  out  N  stored state.
- qn  out  N  always ~q, combinational.
- chg  out  N  registered one-cycle pulse when q changed on the previous edge.
- err  out  N  sticky flag: channel saw S=R=1 while en=1.
- vcnt  out  CNT_W  saturating count of edges with any S=R=1 while en=1.

Behaviour:
- Reset (clr_n=0, asynchronous, any time including mid-operation):
  - q=INIT, chg=0, err=0, vcnt=0, effective immediately.
  - Release is synchronous to the next clk edge; the first update happens on the first rising edge with clr_n=1.
- en=0: q, err and vcnt hold; chg is 0 on the next edge; err_clr is still honoured.
- en=1, per channel i, next q on the rising edge:
  - s=0 r=0: hold.
  - s=1 r=0: q=1.
  - s=0 r=1: q=0.
  - s=1 r=1, by MODE:
    - MODE0: q=0.
    - MODE1: q=1.
    - MODE2: q=~q.
    - MODE3: hold.
- Latency: one clock from s/r to q. chg[i] is asserted on the edge after q[i] changes and lasts exactly one cycle.
- Re-setting an already set channel is not a change: chg stays 0.
- Violation, edge with en=1 and s[i]&r[i]=1:
  - err[i] is set, in every MODE.
  - vcnt increments by 1 if any channel violates; multiple violating channels in the same edge still count 1.
  - vcnt saturates at 2^CNT_W-1 and never wraps.
- err_clr=1 on an edge: err=0 and vcnt=0 take priority over a simultaneous violation on that edge. The violation is lost, not counted.
- MODE outside 0..3: elaboration error.

Decomposition:
- Package sr_pkg:
  - mode constants SR_RDOM=0, SR_SDOM=1, SR_TOGGLE=2, SR_HOLDFLAG=3.
  - a function next_q(mode,q,s,r).
- Sub-module sr_cell: one channel holding q, chg and err flops; instantiated N times via generate.
- vcnt and the any-violation OR reduction live in the top.

Test Plan (N=4, CNT_W=3, INIT=4'b0000 unless stated):
- Reset and INIT:
  - Reset with INIT=4'b1010 -> q=1010, qn=0101, err=0, vcnt=0.
  - Pull clr_n low between edges after q=1111 -> q=1010 immediately, before the next edge.
- Basic set/reset, MODE0:
  - s=0011 r=0000 -> q=0011 after one edge, chg=0011 the edge after, then 0000.
  - r=0001 -> q=0010.
- Resolution modes: s=r=0001 on each MODE with starting q=0001:
  - MODE0 -> q=0000.
  - MODE1 -> q=0001.
  - MODE2 -> q=0000, then 0001 on the next violating edge.
  - MODE3 -> q=0001.
  - err=0001 and vcnt=1 in every MODE.
- Saturation: s=r=1111 for 10 edges -> vcnt counts 1 per edge and stays at 7. err=1111.
- err_clr: err_clr=1 together with s=r=0100 -> err=0000, vcnt=0.
- Enable freeze: en=0 with s=1111 -> q and chg unchanged for 5 edges. Raise en -> q=1111 one edge later.

Source files
------------

// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - mode constants and next-state rule for the set/reset flag bank
package sr_pkg;

    localparam logic [1:0] SR_RDOM     = 2'd0;
    localparam logic [1:0] SR_SDOM     = 2'd1;
    localparam logic [1:0] SR_TOGGLE   = 2'd2;
    localparam logic [1:0] SR_HOLDFLAG = 2'd3;

    // Next stored value of one channel; s=r=1 is resolved by the selected mode.
    function automatic logic next_q(input logic [1:0] mode, input logic q,
                                    input logic s, input logic r);
        logic nq;
        nq = q;
        case ({s, r})
            2'b10: nq = 1'b1;
            2'b01: nq = 1'b0;
            2'b11: begin
                case (mode)
                    SR_RDOM:   nq = 1'b0;
                    SR_SDOM:   nq = 1'b1;
                    SR_TOGGLE: nq = ~q;
                    default:   nq = q;
                endcase
            end
            default: nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/sr_cell.sv
// rtl/sr_cell.sv - one set/reset channel with change pulse and sticky violation flag
module sr_cell
    import sr_pkg::*;
#(
    parameter logic [1:0] MODE = SR_RDOM,
    parameter logic       INIT = 1'b0
) (
    input  logic clk,
    input  logic clr_n,
    input  logic en,
    input  logic s,
    input  logic r,
    input  logic err_clr,
    output logic q,
    output logic chg,
    output logic err
);

    // q_last remembers q from before the most recent edge so a change can be
    // reported one edge after it happened.
    logic q_last;
    logic viol;

    assign viol = en & s & r;

    // Stored state, its one-edge-old copy and the change pulse.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q      <= INIT;
            q_last <= INIT;
            chg    <= 1'b0;
        end else begin
            q_last <= q;
            chg    <= en & (q ^ q_last);
            if (en) begin
                q <= next_q(MODE, q, s, r);
            end
        end
    end

    // Sticky violation flag; a clear wins over a violation on the same edge.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            err <= 1'b0;
        end else if (err_clr) begin
            err <= 1'b0;
        end else if (viol) begin
            err <= 1'b1;
        end
    end

endmodule

// File: rtl/sr_ff_bank.sv
// rtl/sr_ff_bank.sv - N-channel clocked set/reset flag bank with violation counter
module sr_ff_bank
    import sr_pkg::*;
#(
    parameter int             N     = 4,
    parameter int             MODE  = 0,
    parameter logic [N-1:0]   INIT  = {N{1'b0}},
    parameter int             CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic [N-1:0]     s,
    input  logic [N-1:0]     r,
    input  logic             err_clr,
    output logic [N-1:0]     q,
    output logic [N-1:0]     qn,
    output logic [N-1:0]     chg,
    output logic [N-1:0]     err,
    output logic [CNT_W-1:0] vcnt
);

    if (MODE < 0 || MODE > 3) begin : g_bad_mode
        $error("sr_ff_bank: MODE must be 0..3");
    end

    localparam logic [CNT_W-1:0] VCNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] VCNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic any_viol;

    assign any_viol = en & (|(s & r));
    assign qn       = ~q;

    for (genvar i = 0; i < N; i++) begin : g_cell
        sr_cell #(
            .MODE (2'(MODE)),
            .INIT (INIT[i])
        ) u_cell (
            .clk     (clk),
            .clr_n   (clr_n),
            .en      (en),
            .s       (s[i]),
            .r       (r[i]),
            .err_clr (err_clr),
            .q       (q[i]),
            .chg     (chg[i]),
            .err     (err[i])
        );
    end

    // One count per edge with any violating channel, saturating at all-ones.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            vcnt <= '0;
        end else if (err_clr) begin
            vcnt <= '0;
        end else if (any_viol && vcnt != VCNT_MAX) begin
            vcnt <= vcnt + VCNT_ONE;
        end
    end

endmodule

// File: tb/tb_sr_ff_bank.sv
// tb/tb_sr_ff_bank.sv - scoreboard bench: four banks, one per resolution mode
module tb_sr_ff_bank;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        en;
    logic [3:0]  s;
    logic [3:0]  r;
    logic        err_clr;
    logic [15:0] q_all, qn_all, chg_all, err_all;
    logic [11:0] vcnt_all;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_dut
        sr_ff_bank #(
            .N     (4),
            .MODE  (m),
            .INIT  ((m % 2 == 0) ? 4'b1010 : 4'b0000),
            .CNT_W (3)
        ) u_dut (
            .clk     (clk),
            .clr_n   (clr_n),
            .en      (en),
            .s       (s),
            .r       (r),
            .err_clr (err_clr),
            .q       (q_all[m*4 +: 4]),
            .qn      (qn_all[m*4 +: 4]),
            .chg     (chg_all[m*4 +: 4]),
            .err     (err_all[m*4 +: 4]),
            .vcnt    (vcnt_all[m*3 +: 3])
        );
    end

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] chg;
        logic [15:0] err;
        logic [11:0] vcnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state, one entry per mode instance
    bit [3:0] mq[4];
    bit [3:0] mlast[4];
    bit [3:0] mchg[4];
    bit [3:0] merr[4];
    int       mvcnt[4];

    function automatic bit [3:0] init_of(int m);
        return (m % 2 == 0) ? 4'b1010 : 4'b0000;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 4; m++) begin
            mq[m] = init_of(m); mlast[m] = 0; mchg[m] = 0; merr[m] = 0; mvcnt[m] = 0;
        end
    endtask

    task automatic model_edge(input bit [3:0] ss, input bit [3:0] rr, input bit e, input bit ec);
        for (int m = 0; m < 4; m++) begin
            bit [3:0] nq;
            bit [3:0] viol;
            nq = mq[m];
            if (e) begin
                for (int i = 0; i < 4; i++) begin
                    if (ss[i] && !rr[i])      nq[i] = 1;
                    else if (!ss[i] && rr[i]) nq[i] = 0;
                    else if (ss[i] && rr[i]) begin
                        if (m == 0)      nq[i] = 0;
                        else if (m == 1) nq[i] = 1;
                        else if (m == 2) nq[i] = !mq[m][i];
                    end
                end
            end
            mchg[m]  = e ? mlast[m] : 4'b0;
            mlast[m] = nq ^ mq[m];
            mq[m]    = nq;
            viol     = e ? (ss & rr) : 4'b0;
            if (ec) begin
                merr[m] = 0; mvcnt[m] = 0;
            end else begin
                merr[m] = merr[m] | viol;
                if (viol != 0) mvcnt[m] = (mvcnt[m] >= 7) ? 7 : mvcnt[m] + 1;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t x;
        for (int m = 0; m < 4; m++) begin
            x.q[m*4 +: 4]    = mq[m];
            x.chg[m*4 +: 4]  = mchg[m];
            x.err[m*4 +: 4]  = merr[m];
            x.vcnt[m*3 +: 3] = 3'(mvcnt[m]);
        end
        return x;
    endfunction

    // One clock: drive at negedge, update the model at posedge, optionally
    // pull reset low mid-cycle, then queue the expected outputs.
    task automatic step(input bit [3:0] ss, input bit [3:0] rr, input bit e,
                        input bit ec, input bit async_rst);
        @(negedge clk);
        clr_n = 1'b1; s = ss; r = rr; en = e; err_clr = ec;
        @(posedge clk);
        model_edge(ss, rr, e, ec);
        #1;
        if (async_rst) begin
            clr_n = 1'b0;
            model_reset();
        end
        exp_q.push_back(model_out());
    endtask

    // Monitor: compares DUT outputs against the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t x;
                x = exp_q.pop_front();
                checks++;
                if (q_all !== x.q) begin
                    errors++; $display("FAIL q act=%h exp=%h", q_all, x.q);
                end
                checks++;
                if (qn_all !== ~x.q) begin
                    errors++; $display("FAIL qn act=%h exp=%h", qn_all, ~x.q);
                end
                checks++;
                if (chg_all !== x.chg) begin
                    errors++; $display("FAIL chg act=%h exp=%h", chg_all, x.chg);
                end
                checks++;
                if (err_all !== x.err) begin
                    errors++; $display("FAIL err act=%h exp=%h", err_all, x.err);
                end
                checks++;
                if (vcnt_all !== x.vcnt) begin
                    errors++; $display("FAIL vcnt act=%h exp=%h", vcnt_all, x.vcnt);
                end
            end
        end
    end

    initial begin
        clr_n = 1'b0; en = 1'b0; s = '0; r = '0; err_clr = 1'b0;
        model_reset();
        exp_q.push_back(model_out());
        @(negedge clk);
        // Basic set / reset and change pulse
        step(4'b0011, 4'b0000, 1, 0, 0);
        step(4'b0000, 4'b0000, 1, 0, 0);
        step(4'b0000, 4'b0000, 1, 0, 0);
        step(4'b0000, 4'b0001, 1, 0, 0);
        step(4'b0001, 4'b0000, 1, 0, 0);
        step(4'b0001, 4'b0000, 1, 0, 0);
        // S=R=1 resolution, twice to see the toggle come back
        step(4'b0001, 4'b0001, 1, 0, 0);
        step(4'b0001, 4'b0001, 1, 0, 0);
        // Saturation of the violation counter
        for (int k = 0; k < 10; k++) step(4'b1111, 4'b1111, 1, 0, 0);
        // Clear wins over a simultaneous violation
        step(4'b0100, 4'b0100, 1, 1, 0);
        step(4'b0000, 4'b0000, 1, 0, 0);
        // Enable freeze, then release
        for (int k = 0; k < 5; k++) step(4'b1111, 4'b0000, 0, 0, 0);
        step(4'b1111, 4'b0000, 1, 0, 0);
        step(4'b0000, 4'b0000, 1, 0, 0);
        // Asynchronous clear between edges
        step(4'b0000, 4'b0000, 1, 0, 1);
        step(4'b0000, 4'b0000, 1, 0, 0);
        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            bit [3:0] rs, rr;
            rs = 4'($urandom);
            rr = 4'($urandom) & 4'($urandom);
            step(rs, rr, ($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 49) == 0));
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL drain act=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
